// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with registered carry; SERIAL_ADDER_SUB_EN adds A-B via Sub
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub_in;

    logic p, g, s, t, c_next, last_bit, accept;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = Sub;
`else
    assign sub_in = 1'b0;
`endif

    // Two cascaded half adders plus OR form the full adder for the current bit.
    always_comb begin
        p        = opa[0] ^ opb[0];
        g        = opa[0] & opb[0];
        s        = p ^ carry;
        t        = p & carry;
        c_next   = g | t;
        last_bit = (cnt == CW'(WIDTH - 1));
        accept   = (state == IDLE) && Start;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sum/Cout are written only on the final bit so partial results never leak out.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            opa   <= '0;
            opb   <= '0;
            work  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (accept) begin
            opa   <= A;
            opb   <= sub_in ? ~B : B;
            carry <= sub_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            work  <= {s, work[WIDTH-1:1]};
            carry <= c_next;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                Sum  <= {s, work[WIDTH-1:1]};
                Cout <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

    logic       CLK;
    logic       Reset_L;
    logic       Start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Sub;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       Cout;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .Start   (Start),
        .A       (A),
        .B       (B),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub     (Sub),
`endif
        .Busy    (Busy),
        .Done    (Done),
        .Sum     (Sum),
        .Cout    (Cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation from IDLE: operands are scrambled right after acceptance.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sb,
                          input logic [7:0] es, input logic ec,
                          input logic [7:0] ps, input logic pc);
        A = a; B = b; Sub = sb; Start = 1'b1;
        step();
        Start = 1'b0; A = ~a; B = a ^ b; Sub = ~sb;
        chk("accept_busy", {31'd0, Busy}, 32'd1);
        chk("accept_done", {31'd0, Done}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("shift_busy", {31'd0, Busy}, 32'd1);
            chk("shift_done", {31'd0, Done}, 32'd0);
            chk("shift_sum_hold", {24'd0, Sum}, {24'd0, ps});
            chk("shift_cout_hold", {31'd0, Cout}, {31'd0, pc});
        end
        step();
        chk("done_pulse", {31'd0, Done}, 32'd1);
        chk("done_busy", {31'd0, Busy}, 32'd1);
        chk("done_sum", {24'd0, Sum}, {24'd0, es});
        chk("done_cout", {31'd0, Cout}, {31'd0, ec});
        step();
        chk("after_done", {31'd0, Done}, 32'd0);
        chk("after_busy", {31'd0, Busy}, 32'd0);
        repeat (3) step();
        chk("held_sum", {24'd0, Sum}, {24'd0, es});
        chk("held_cout", {31'd0, Cout}, {31'd0, ec});
    endtask

    initial begin
        Reset_L = 1'b0; Start = 1'b0; A = 8'h00; B = 8'h00; Sub = 1'b0;
        repeat (3) step();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_sum", {24'd0, Sum}, 32'd0);
        chk("rst_cout", {31'd0, Cout}, 32'd0);
        Reset_L = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_busy", {31'd0, Busy}, 32'd0);
            chk("idle_done", {31'd0, Done}, 32'd0);
            chk("idle_sum", {24'd0, Sum}, 32'd0);
            chk("idle_cout", {31'd0, Cout}, 32'd0);
        end

        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h8D, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Start held high: accepts at k=0 and k=10, Done at k=8 and k=18.
        A = 8'h01; B = 8'h02; Start = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("held_start_done", {31'd0, Done}, {31'd0, (k == 8 || k == 18)});
            chk("held_start_busy", {31'd0, Busy}, {31'd0, !(k == 9 || k >= 19)});
            chk("held_start_sum", {24'd0, Sum}, (k >= 8) ? 32'h03 : 32'h00);
            if (k == 10) Start = 1'b0;
        end

        // Reset in the middle of an operation.
        A = 8'h5A; B = 8'h33; Start = 1'b1;
        step();
        Start = 1'b0;
        repeat (4) step();
        Reset_L = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_done", {31'd0, Done}, 32'd0);
        chk("midrst_sum", {24'd0, Sum}, 32'd0);
        chk("midrst_cout", {31'd0, Cout}, 32'd0);
        step();
        Reset_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("postrst_done", {31'd0, Done}, 32'd0);
            chk("postrst_busy", {31'd0, Busy}, 32'd0);
        end
        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 8'h00, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 8'h8D, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 8'h0F, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
